// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with RV32M MUL: fetch, decode, execute, memory access and
// writeback all complete in one clock, so every rising edge retires one instruction.
module rv32i_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_read,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_out,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_addr,
  output logic [31:0] data_in,
  input  logic [31:0] data_out
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_r;
  logic [31:0] regs_r [0:31];

  logic [6:0]  opcode_s, funct7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s, alu_f3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0] rs1_val_s, rs2_val_s, pc_plus4_s;
  logic [31:0] alu_b_s, alu_res_s, load_shift_s, wr_data_s, next_pc_s;
  logic        alu_alt_s, branch_s, wr_en_s, load_s, store_s;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign opcode_s   = instr_out[6:0];
  assign rd_s       = instr_out[11:7];
  assign funct3_s   = instr_out[14:12];
  assign rs1_s      = instr_out[19:15];
  assign rs2_s      = instr_out[24:20];
  assign funct7_s   = instr_out[31:25];
  assign imm_i_s    = {{20{instr_out[31]}}, instr_out[31:20]};
  assign imm_s_s    = {{20{instr_out[31]}}, instr_out[31:25], instr_out[11:7]};
  assign imm_b_s    = {{19{instr_out[31]}}, instr_out[31], instr_out[7], instr_out[30:25],
                       instr_out[11:8], 1'b0};
  assign imm_u_s    = {instr_out[31:12], 12'd0};
  assign imm_j_s    = {{11{instr_out[31]}}, instr_out[31], instr_out[19:12], instr_out[20],
                       instr_out[30:21], 1'b0};
  // x0 is cleared at reset and never written, so it always reads zero
  assign rs1_val_s  = regs_r[rs1_s];
  assign rs2_val_s  = regs_r[rs2_s];
  assign pc_plus4_s = pc_r + 32'd4;

  // ALU operand/operation select; loads, stores and others use the adder for addresses
  always_comb begin
    alu_b_s   = imm_i_s;
    alu_f3_s  = 3'b000;
    alu_alt_s = 1'b0;
    case (opcode_s)
      OP_REG: begin
        alu_b_s   = rs2_val_s;
        alu_f3_s  = funct3_s;
        alu_alt_s = funct7_s[5];
      end
      OP_IMM: begin
        alu_f3_s  = funct3_s;
        alu_alt_s = (funct3_s == 3'b101) & funct7_s[5];
      end
      OP_STORE: alu_b_s = imm_s_s;
      default:  alu_b_s = imm_i_s;
    endcase
  end

  assign alu_res_s    = alu_fn(rs1_val_s, alu_b_s, alu_f3_s, alu_alt_s);
  assign load_shift_s = data_out >> {alu_res_s[1:0], 3'b000};

  // Branch condition evaluation
  always_comb begin
    case (funct3_s)
      3'b000:  branch_s = (rs1_val_s == rs2_val_s);
      3'b001:  branch_s = (rs1_val_s != rs2_val_s);
      3'b100:  branch_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
      3'b101:  branch_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
      3'b110:  branch_s = (rs1_val_s < rs2_val_s);
      3'b111:  branch_s = (rs1_val_s >= rs2_val_s);
      default: branch_s = 1'b0;
    endcase
  end

  // Instruction control: writeback value, next PC and memory strobes
  always_comb begin
    next_pc_s = pc_plus4_s;
    wr_en_s   = 1'b0;
    wr_data_s = alu_res_s;
    load_s    = 1'b0;
    store_s   = 1'b0;
    case (opcode_s)
      OP_LUI:   begin wr_en_s = 1'b1; wr_data_s = imm_u_s; end
      OP_AUIPC: begin wr_en_s = 1'b1; wr_data_s = pc_r + imm_u_s; end
      OP_JAL: begin
        wr_en_s   = 1'b1;
        wr_data_s = pc_plus4_s;
        next_pc_s = pc_r + imm_j_s;
      end
      OP_JALR: begin
        wr_en_s   = 1'b1;
        wr_data_s = pc_plus4_s;
        next_pc_s = alu_res_s & 32'hFFFF_FFFE;
      end
      OP_BRANCH: begin
        if (branch_s) next_pc_s = pc_r + imm_b_s;
        else          next_pc_s = pc_plus4_s;
      end
      OP_LOAD: begin
        load_s  = 1'b1;
        wr_en_s = 1'b1;
        case (funct3_s)
          3'b000:  wr_data_s = {{24{load_shift_s[7]}}, load_shift_s[7:0]};
          3'b001:  wr_data_s = {{16{load_shift_s[15]}}, load_shift_s[15:0]};
          3'b010:  wr_data_s = data_out;
          3'b100:  wr_data_s = {24'd0, load_shift_s[7:0]};
          3'b101:  wr_data_s = {16'd0, load_shift_s[15:0]};
          default: begin load_s = 1'b0; wr_en_s = 1'b0; end
        endcase
      end
      OP_STORE: begin
        if (funct3_s <= 3'b010) store_s = 1'b1;
        else                    store_s = 1'b0;
      end
      OP_IMM: wr_en_s = 1'b1;
      OP_REG: begin
        if (funct7_s == 7'b0000001) begin
          wr_en_s   = (funct3_s == 3'b000);
          wr_data_s = rs1_val_s * rs2_val_s;
        end else if ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000)) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Architectural state: PC and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
    end else begin
      pc_r <= next_pc_s;
      if (wr_en_s && (rd_s != 5'd0)) regs_r[rd_s] <= wr_data_s;
    end
  end

  assign instr_read = ~reset;
  assign instr_addr = reset ? RESET_PC : pc_r;
  assign data_read  = ~reset & load_s;
  assign data_write = ~reset & store_s;
  assign data_addr  = reset ? 32'd0 : alu_res_s;
  assign data_in    = reset ? 32'd0 : rs2_val_s;

endmodule

// File: tb/tb_rv32i_cpu.sv
// Bench for rv32i_cpu: directed program from the datasheet plus a random instruction
// block, all checked against an instruction-level reference model.
module tb_rv32i_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_read, data_read, data_write;
  logic [31:0] instr_addr, instr_out, data_addr, data_in, data_out;

  logic [31:0] imem   [0:511];
  logic [31:0] dmem   [0:255];
  logic [31:0] m_dmem [0:255];
  logic [31:0] m_x    [0:31];
  logic [31:0] m_pc;
  int checks = 0;
  int errors = 0;

  rv32i_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_addr(instr_addr), .instr_out(instr_out),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  assign instr_out = imem[instr_addr[10:2]];
  assign data_out  = dmem[data_addr[9:2]];

  // word-wide data memory written on the rising edge
  always @(posedge clk) begin
    if (data_write) dmem[data_addr[9:2]] <= data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return 32'(int'(a) >>> sh);
        else     return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
  endtask

  // Executes the instruction at m_pc and reports the memory activity it should cause
  task automatic model_step(output logic ld, output logic st,
                            output logic [31:0] addr, output logic [31:0] wdat);
    logic [31:0] ins, a, b, res, word, shw, npc, imm_i, imm_s, imm_b, imm_j, upper;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr, taken;
    ins   = imem[m_pc[10:2]];
    f3    = ins[14:12];
    rd    = ins[11:7];
    a     = m_x[ins[19:15]];
    b     = m_x[ins[24:20]];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    upper = {ins[31:12], 12'd0};
    ld = 1'b0; st = 1'b0; addr = a + imm_i; wdat = b;
    wr = 1'b0; res = 32'd0; npc = m_pc + 32'd4; taken = 1'b0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; res = upper; end
      7'h17: begin wr = 1'b1; res = m_pc + upper; end
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + imm_j; end
      7'h67: begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + imm_i) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = (int'(a) < int'(b));
          3'd5: taken = (int'(a) >= int'(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) npc = m_pc + imm_b;
      end
      7'h03: begin
        word = m_dmem[addr[9:2]];
        shw  = word >> (int'(addr[1:0]) * 8);
        ld = 1'b1; wr = 1'b1;
        case (f3)
          3'd0: res = 32'($signed(shw[7:0]));
          3'd1: res = 32'($signed(shw[15:0]));
          3'd2: res = word;
          3'd4: res = {24'd0, shw[7:0]};
          3'd5: res = {16'd0, shw[15:0]};
          default: begin ld = 1'b0; wr = 1'b0; end
        endcase
      end
      7'h23: begin
        addr = a + imm_s;
        if (f3 <= 3'd2) begin st = 1'b1; m_dmem[addr[9:2]] = b; end
      end
      7'h13: begin wr = 1'b1; res = alu_ref(f3, (f3 == 3'd5) && ins[30], a, imm_i); end
      7'h33: begin
        if (ins[31:25] == 7'd1) begin
          if (f3 == 3'd0) begin wr = 1'b1; res = 32'(longint'(a) * longint'(b)); end
        end else begin
          wr = 1'b1; res = alu_ref(f3, ins[30], a, b);
        end
      end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = npc;
  endtask

  // One retired instruction: check outputs before the edge, state after it
  task automatic step(input string tag);
    logic        ld, st;
    logic [31:0] addr, wdat, pre_pc;
    pre_pc = m_pc;
    model_step(ld, st, addr, wdat);
    check({tag, ":pc"}, instr_addr, pre_pc);
    check({tag, ":rd_strobe"}, {31'd0, data_read}, {31'd0, ld});
    check({tag, ":wr_strobe"}, {31'd0, data_write}, {31'd0, st});
    if (ld || st) check({tag, ":addr"}, data_addr, addr);
    if (st) check({tag, ":wdata"}, data_in, wdat);
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 32; r++) check($sformatf("%s:x%0d", tag, r), dut.regs_r[r], m_x[r]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    int k;
    k   = int'($urandom_range(0, 9));
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case (k)
      0, 1: begin
        if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
        if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
        return {imm, rs1, f3, rd, 7'h13};
      end
      2: begin
        f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      3: begin
        if ($urandom_range(0, 3) != 0) f3 = 3'd0;
        return {7'h01, rs2, rs1, f3, rd, 7'h33};
      end
      4: return {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      5: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        imm = 12'($urandom_range(0, 1023));
        if (f3 == 3'd2) imm = imm & 12'hFFC;
        if (f3 == 3'd1 || f3 == 3'd5) imm = imm & 12'hFFE;
        return {imm, 5'd0, f3, rd, 7'h03};
      end
      6: begin
        f3  = 3'($urandom_range(0, 2));
        imm = 12'($urandom_range(0, 1023));
        return {imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'h23};
      end
      7: begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd4;
          3: f3 = 3'd5;
          4: f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
        return {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3, 5'b01000, 7'h63};
      end
      8: return {20'h00800, rd, 7'h6F};
      default: return ($urandom_range(0, 1) == 1) ? 32'h0000_000F : 32'h0000_0073;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 512; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      dmem[i] = v;
      m_dmem[i] = v;
    end
    dmem[1] = 32'h0000_00F0; m_dmem[1] = 32'h0000_00F0;
    dmem[2] = 32'h0000_0080; m_dmem[2] = 32'h0000_0080;
    dmem[3] = 32'h8001_8000; m_dmem[3] = 32'h8001_8000;
    imem[0]  = 32'h0060_0513;  // addi a0,x0,6
    imem[1]  = 32'h0010_0293;  // addi t0,x0,1
    imem[2]  = 32'h0010_0593;  // addi a1,x0,1
    imem[3]  = 32'h02b2_82b3;  // mul t0,t0,a1
    imem[4]  = 32'h0015_8593;  // addi a1,a1,1
    imem[5]  = 32'hfea5_9ce3;  // bne a1,a0,-8
    imem[6]  = 32'h0050_2023;  // sw x5,0(x0)
    imem[7]  = 32'h0040_2303;  // lw x6,4(x0)
    imem[8]  = 32'h0080_0383;  // lb x7,8(x0)
    imem[9]  = 32'h00D0_4403;  // lbu x8,13(x0)
    imem[10] = 32'h00E0_1483;  // lh x9,14(x0)
    imem[11] = 32'h0050_0013;  // addi x0,x0,5
    imem[16] = 32'h0080_00EF;  // jal x1,+8 at 0x40
    imem[17] = 32'h0010_0F93;  // skipped
    imem[18] = 32'h0510_0167;  // jalr x2,0x51(x0)
    imem[19] = 32'h0010_0F93;  // skipped
    for (int i = 20; i < 218; i++) imem[i] = rand_instr();
    imem[220] = 32'h0000_006F; // jal x0,0
    model_reset();

    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_iread", {31'd0, instr_read}, 32'd0);
    check("rst_iaddr", instr_addr, 32'd0);
    check("rst_dread", {31'd0, data_read}, 32'd0);
    check("rst_dwrite", {31'd0, data_write}, 32'd0);
    check("rst_daddr", data_addr, 32'd0);
    check("rst_din", data_in, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_iaddr", instr_addr, 32'd0);
    check("rel_iread", {31'd0, instr_read}, 32'd1);
    check("rel_dread", {31'd0, data_read}, 32'd0);
    check("rel_dwrite", {31'd0, data_write}, 32'd0);

    step("addi_a0");
    check("pc_after1", instr_addr, 32'd4);
    step("addi_t0");
    check("pc_after2", instr_addr, 32'd8);
    check("x10_six", dut.regs_r[10], 32'd6);
    check("x5_one", dut.regs_r[5], 32'd1);

    for (int n = 0; n < 60 && instr_addr != 32'd24; n++) step("fact");
    check("fact_exit", instr_addr, 32'd24);
    check("fact_x5", dut.regs_r[5], 32'd120);
    check("fact_x11", dut.regs_r[11], 32'd6);
    check("fact_x10", dut.regs_r[10], 32'd6);

    check("sw_write", {31'd0, data_write}, 32'd1);
    check("sw_addr", data_addr, 32'd0);
    check("sw_data", data_in, 32'd120);
    step("sw");
    check("sw_once", {31'd0, data_write}, 32'd0);
    check("sw_mem", dmem[0], 32'd120);
    check("lw_read", {31'd0, data_read}, 32'd1);
    step("lw");
    check("lw_x6", dut.regs_r[6], 32'h0000_00F0);
    step("lb");
    check("lb_x7", dut.regs_r[7], 32'hFFFF_FF80);
    step("lbu");
    check("lbu_x8", dut.regs_r[8], 32'h0000_0080);
    step("lh");
    check("lh_x9", dut.regs_r[9], 32'hFFFF_8001);
    step("addi_x0");
    check("x0_zero", dut.regs_r[0], 32'd0);

    for (int n = 0; n < 4; n++) step("nop");
    check("jal_pc", instr_addr, 32'h0000_0040);
    step("jal");
    check("jal_x1", dut.regs_r[1], 32'h0000_0044);
    check("jal_next", instr_addr, 32'h0000_0048);
    step("jalr");
    check("jalr_x2", dut.regs_r[2], 32'h0000_004C);
    check("jalr_next", instr_addr, 32'h0000_0050);

    for (int n = 0; n < 400 && m_pc != 32'd880; n++) step("rnd");
    check("rnd_end", instr_addr, 32'd880);
    for (int i = 0; i < 256; i++) check($sformatf("dmem%0d", i), dmem[i], m_dmem[i]);

    step("spin");
    #2 reset = 1'b1;
    #1;
    check("mid_iaddr", instr_addr, 32'd0);
    check("mid_iread", {31'd0, instr_read}, 32'd0);
    check("mid_dwrite", {31'd0, data_write}, 32'd0);
    check("mid_daddr", data_addr, 32'd0);
    check("mid_x5", dut.regs_r[5], 32'd0);
    check("mid_x10", dut.regs_r[10], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rel_iaddr", instr_addr, 32'd0);
    check("mid_rel_iread", {31'd0, instr_read}, 32'd1);
    step("re_a0");
    step("re_t0");
    check("re_pc", instr_addr, 32'd8);
    check("re_x10", dut.regs_r[10], 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
